// File: rtl/axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_packet_arbiter
// Description : Round-robin AXI-Stream packet arbiter. Merges NUM_PORTS slave
//               streams onto one registered master stream without ever
//               interleaving packets. m_id carries the source port index.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             s_valid,
  output logic [NUM_PORTS-1:0]             s_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_data,
  input  logic [NUM_PORTS*DEST_WIDTH-1:0]  s_dest,
  input  logic [NUM_PORTS-1:0]             s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [ID_WIDTH-1:0]              m_id,
  output logic [DEST_WIDTH-1:0]            m_dest,
  output logic                             m_last
);

  localparam int C_PW = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  logic [C_PW-1:0]       r_owner;
  logic [C_PW-1:0]       r_rr_ptr;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [ID_WIDTH-1:0]   r_m_id;
  logic [DEST_WIDTH-1:0] r_m_dest;
  logic                  r_m_last;

  logic                  w_rr_found;
  logic [C_PW-1:0]       w_rr_idx;
  logic [C_PW-1:0]       w_sel_idx;
  logic                  w_sel_valid;
  logic                  w_can_load;
  logic                  w_fire;
  logic [C_PW-1:0]       w_next_ptr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [DEST_WIDTH-1:0] w_sel_dest;
  logic                  w_sel_last;

  // Port index arithmetic modulo NUM_PORTS (works for non-power-of-two counts).
  function automatic logic [C_PW-1:0] f_wrap_add(input logic [C_PW-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NUM_PORTS) t = t - NUM_PORTS;
    return t[C_PW-1:0];
  endfunction

  // Round-robin search: first valid port starting at r_rr_ptr.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_rr_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_rr_found && s_valid[f_wrap_add(r_rr_ptr, i)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = f_wrap_add(r_rr_ptr, i);
      end
    end
  end

  // While a packet is in flight the owner is selected unconditionally, so a
  // bubble on the owner holds the output instead of letting another port in.
  assign w_sel_idx   = (r_state == ST_LOCKED) ? r_owner : w_rr_idx;
  assign w_sel_valid = (r_state == ST_LOCKED) ? s_valid[r_owner] : w_rr_found;
  assign w_can_load  = !r_m_valid || m_ready;
  assign w_fire      = w_sel_valid && w_can_load && !rst;
  assign w_next_ptr  = f_wrap_add(w_sel_idx, 1);

  assign w_sel_data  = s_data[int'(w_sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_dest  = s_dest[int'(w_sel_idx)*DEST_WIDTH +: DEST_WIDTH];
  assign w_sel_last  = s_last[w_sel_idx];

  // One-hot ready toward the selected port, only when its beat is taken.
  always_comb begin
    s_ready = '0;
    if (w_fire) s_ready[w_sel_idx] = 1'b1;
  end

  // Arbitration FSM and output register; payload only changes on a new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_id    <= '0;
      r_m_dest  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      if (w_can_load) r_m_valid <= w_fire;
      if (w_fire) begin
        r_m_data <= w_sel_data;
        r_m_id   <= ID_WIDTH'(w_sel_idx);
        r_m_dest <= w_sel_dest;
        r_m_last <= w_sel_last;
        case (r_state)
          ST_IDLE: begin
            if (w_sel_last) begin
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_owner <= w_sel_idx;
              r_state <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (w_sel_last) begin
              r_rr_ptr <= w_next_ptr;
              r_state  <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_id    = r_m_id;
  assign m_dest  = r_m_dest;
  assign m_last  = r_m_last;

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_packet_arbiter
// Description : Self-checking bench for axis_packet_arbiter. Expected output is
//               a packet-level round-robin model over per-port packet lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_packet_arbiter;
  localparam int NP = 4, DW = 64, IW = 8, EW = 8, MAXB = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   s_valid, s_ready, s_last;
  logic [NP*DW-1:0] s_data;
  logic [NP*EW-1:0] s_dest;
  logic            m_valid, m_ready, m_last;
  logic [DW-1:0]   m_data;
  logic [IW-1:0]   m_id;
  logic [EW-1:0]   m_dest;

  always #5 clk = ~clk;

  axis_packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(EW)) u_dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_dest(s_dest), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id), .m_dest(m_dest), .m_last(m_last)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [EW-1:0] dest;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] src_data [NP][MAXB];
  logic [EW-1:0] src_dest [NP][MAXB];
  logic          src_last [NP][MAXB];
  int src_len[NP], src_ptr[NP], bubble[NP], bub_cfg[NP];
  int mdl_rr, checks, failures, cyc, n_out, first_out, last_out, stall, t0;
  bit rand_mode;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NP; p++) begin
      src_len[p] = 0; src_ptr[p] = 0; bubble[p] = 0; bub_cfg[p] = 0;
    end
  endtask

  task automatic load_pkt(input int p, input int len);
    for (int k = 0; k < len; k++) begin
      src_data[p][src_len[p]] = {$urandom, $urandom};
      src_dest[p][src_len[p]] = EW'($urandom);
      src_last[p][src_len[p]] = (k == len - 1);
      src_len[p]++;
    end
  endtask

  // Packet-level round robin: next packet comes from the first port at or
  // after the pointer that still has packets; pointer moves past the winner.
  task automatic build_expected();
    int cur[NP];
    int sel;
    for (int i = 0; i < NP; i++) cur[i] = src_ptr[i];
    while (1) begin
      sel = -1;
      for (int k = 0; k < NP; k++)
        if (sel < 0 && cur[(mdl_rr + k) % NP] < src_len[(mdl_rr + k) % NP]) sel = (mdl_rr + k) % NP;
      if (sel < 0) break;
      do begin
        exp_q.push_back({src_data[sel][cur[sel]], IW'(sel), src_dest[sel][cur[sel]], src_last[sel][cur[sel]]});
        cur[sel]++;
      end while (!src_last[sel][cur[sel] - 1]);
      mdl_rr = (sel + 1) % NP;
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      if (src_ptr[p] < src_len[p] && bubble[p] == 0) begin
        s_valid[p]          = 1'b1;
        s_data[p*DW +: DW]  = src_data[p][src_ptr[p]];
        s_dest[p*EW +: EW]  = src_dest[p][src_ptr[p]];
        s_last[p]           = src_last[p][src_ptr[p]];
      end else begin
        s_valid[p]          = 1'b0;
        s_data[p*DW +: DW]  = '0;
        s_dest[p*EW +: EW]  = '0;
        s_last[p]           = 1'b0;
      end
    end
  endtask

  task automatic start_stats();
    n_out = 0; first_out = -1; last_out = -1; t0 = cyc;
  endtask

  // One clock: sample/check at negedge, advance sources at posedge+1.
  task automatic tick();
    logic [NP-1:0] acc;
    beat_t got, want;
    @(negedge clk);
    check("s_ready_onehot", 128'($countones(s_ready) <= 1), 128'(1));
    check("s_ready_no_valid", 128'(s_ready & ~s_valid), 128'(0));
    acc = s_valid & s_ready;
    got = {m_data, m_id, m_dest, m_last};
    if (m_valid && !m_ready) begin
      check("stall_s_ready", 128'(s_ready), 128'(0));
      if (exp_q.size() > 0) check("stall_payload", 128'(got), 128'(exp_q[0]));
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 128'(exp_q.size()), 128'(1));
      end else begin
        want = exp_q.pop_front();
        check("beat", 128'(got), 128'(want));
      end
      if (n_out == 0) first_out = cyc;
      last_out = cyc;
      n_out++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) if (bubble[p] > 0) bubble[p]--;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        if (!src_last[p][src_ptr[p]]) begin
          if (rand_mode) begin
            if ($urandom_range(0, 3) == 0) bubble[p] = int'($urandom_range(1, 3));
          end else if (bub_cfg[p] > 0) begin
            bubble[p] = bub_cfg[p];
            bub_cfg[p] = 0;
          end
        end
        src_ptr[p]++;
      end
    end
    if (stall > 0) begin
      m_ready = 1'b0;
      stall--;
    end else begin
      m_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    drive_inputs();
  endtask

  task automatic drain(input int budget, input string tag);
    int n, rem;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    rem = 0;
    for (int p = 0; p < NP; p++) rem += src_len[p] - src_ptr[p];
    check({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_src_consumed"}, 128'(rem), 128'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ready = 1'b1;
    clear_sources();
    exp_q.delete();
    mdl_rr = 0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; stall = 0; rand_mode = 0; mdl_rr = 0;
    m_ready = 1'b1;
    clear_sources();
    // Reset with every port requesting: no ready may leak out.
    rst = 1'b1;
    s_valid = '1; s_data = {NP{64'hA5A5_0000_FFFF_1234}}; s_dest = '1; s_last = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_s_ready", 128'(s_ready), 128'(0));
    check("reset_outputs", 128'({m_valid, m_data, m_id, m_dest, m_last}), 128'(0));
    @(posedge clk);
    #1;
    do_reset();

    // Port 2, three beats, one-cycle latency, back to back.
    load_pkt(2, 3); build_expected(); drive_inputs(); start_stats();
    drain(20, "t1");
    check("t1_latency", 128'(first_out), 128'(t0 + 1));
    check("t1_span", 128'(last_out - first_out), 128'(2));
    check("t1_count", 128'(n_out), 128'(3));

    // Pointer now 3: single-beat packets on ports 3 and 0 wrap 3,0,3,0.
    clear_sources();
    load_pkt(3, 1); load_pkt(3, 1); load_pkt(0, 1); load_pkt(0, 1);
    build_expected(); drive_inputs(); start_stats();
    drain(20, "t5");
    check("t5_count", 128'(n_out), 128'(4));
    check("t5_span", 128'(last_out - first_out), 128'(3));

    // All ports busy with 2-beat packets: ids 0,0,1,1,2,2,3,3,0,0, no gaps.
    do_reset();
    load_pkt(0, 2); load_pkt(1, 2); load_pkt(2, 2); load_pkt(3, 2); load_pkt(0, 2);
    build_expected(); drive_inputs(); start_stats();
    drain(40, "t2");
    check("t2_count", 128'(n_out), 128'(10));
    check("t2_span", 128'(last_out - first_out), 128'(9));

    // Owner bubble of 5 cycles holds the lock against waiting port 3.
    clear_sources();
    load_pkt(1, 3); load_pkt(3, 2); bub_cfg[1] = 5;
    build_expected(); drive_inputs(); start_stats();
    drain(40, "t3");
    check("t3_count", 128'(n_out), 128'(5));
    check("t3_span", 128'(last_out - first_out), 128'(9));

    // Back-pressure for 4 cycles with output valid.
    clear_sources();
    load_pkt(0, 4); build_expected(); drive_inputs(); start_stats();
    tick();
    m_ready = 1'b0; stall = 3;
    drain(40, "t4");
    check("t4_first_out", 128'(first_out), 128'(t0 + 5));
    check("t4_span", 128'(last_out - first_out), 128'(3));
    check("t4_count", 128'(n_out), 128'(4));

    // Reset in the middle of a 4-beat packet from port 0.
    clear_sources();
    load_pkt(0, 4); build_expected(); drive_inputs(); start_stats();
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    check("t6_ready_in_reset", 128'(s_ready), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_sources(); exp_q.delete(); mdl_rr = 0; drive_inputs();
    @(negedge clk);
    check("t6_after_reset", 128'({m_valid, m_data, m_id, m_dest, m_last, s_ready}), 128'(0));
    @(posedge clk);
    #1;
    load_pkt(1, 2); build_expected(); drive_inputs(); start_stats();
    drain(20, "t6");
    check("t6_count", 128'(n_out), 128'(2));

    // Randomized traffic: random packet mix, random back-pressure, owner bubbles.
    rand_mode = 1;
    for (int r = 0; r < 4; r++) begin
      clear_sources();
      for (int p = 0; p < NP; p++) begin
        int np;
        np = int'($urandom_range(0, 3));
        for (int k = 0; k < np; k++) load_pkt(p, int'($urandom_range(1, 5)));
      end
      build_expected(); drive_inputs(); start_stats();
      drain(800, "rand");
    end
    rand_mode = 0;
    m_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
